// File: rtl/uio_pkg.sv
// Shared types and default constants for the uio pin arbiter.
// The FSM state encoding lives here so the top and the bench agree on it.
package uio_pkg;

    localparam int unsigned TURNAROUND_DEF = 1;
    localparam int unsigned MAX_HOLD_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester always wins; on a tie
// the stored pointer decides. The pointer is reloaded when an owner leaves.
module rr_pick2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_load,
    input  logic       i_next,
    output logic       o_pick
);

    logic r_rr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (i_load) begin
            r_rr <= i_next;
        end
    end

    always_comb begin
        o_pick = r_rr;
        if (i_req == 2'b01) begin
            o_pick = 1'b0;
        end else if (i_req == 2'b10) begin
            o_pick = 1'b1;
        end
    end

endmodule

// File: rtl/uio_pin_arbiter.sv
// Arbitrates a shared 8-bit bidirectional pad bank between two requesters,
// with a bounded hold time and an all-released turnaround gap between owners.
module uio_pin_arbiter
    import uio_pkg::*;
#(
    parameter int unsigned TURNAROUND = TURNAROUND_DEF,
    parameter int unsigned MAX_HOLD   = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] out0,
    input  logic [7:0] out1,
    input  logic [7:0] oe0,
    input  logic [7:0] oe1,
    output logic [1:0] gnt,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       busy
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [2:0] GAP_LAST  = 3'(TURNAROUND - 1);

    state_t     r_state;
    logic [7:0] r_hold;
    logic [2:0] r_gap;
    logic [1:0] r_gnt;
    logic       r_busy;

    logic w_owning;
    logic w_owner;
    logic w_ownReq;
    logic w_otherReq;
    logic w_exit;
    logic w_pick;

    assign w_owning   = (r_state == OWN0) || (r_state == OWN1);
    assign w_owner    = (r_state == OWN1);
    assign w_ownReq   = w_owner ? req[1] : req[0];
    assign w_otherReq = w_owner ? req[0] : req[1];
    // Voluntary release and hold-limit preemption share one exit path.
    assign w_exit     = w_owning && (!w_ownReq || ((r_hold == HOLD_LAST) && w_otherReq));

    rr_pick2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .i_req  (req),
        .i_load (w_exit),
        .i_next (~w_owner),
        .o_pick (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= 8'd0;
            r_gap   <= 3'd0;
            r_gnt   <= 2'b00;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req != 2'b00) begin
                        r_state <= w_pick ? OWN1 : OWN0;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_hold  <= 8'd0;
                    end
                end
                OWN0, OWN1: begin
                    if (w_exit) begin
                        r_state <= GAP;
                        r_gnt   <= 2'b00;
                        r_gap   <= 3'd0;
                    end else if (r_hold != HOLD_LAST) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_gap   <= 3'd0;
                    end else begin
                        r_gap <= r_gap + 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        uio_out = 8'h00;
        uio_oe  = 8'h00;
        if (r_state == OWN0) begin
            uio_out = out0;
            uio_oe  = oe0;
        end else if (r_state == OWN1) begin
            uio_out = out1;
            uio_oe  = oe1;
        end
    end

    assign gnt  = r_gnt;
    assign busy = r_busy;

endmodule

// File: doc/uio_pin_arbiter.md
UIO_PIN_ARBITER -- requirements
Module: uio_pin_arbiter

Interface
REQ-001 The block SHALL have parameter TURNAROUND, default 1, meaning the number of idle cycles with all uio_oe low between owners (legal range 1-7).
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles an owner keeps the pins while the other requester waits (legal range 2-255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, 2 bits: level request per requester, index 0 and 1.
REQ-006 The block SHALL have ports out0 and out1, input, 8 bits each: requester pin drive values.
REQ-007 The block SHALL have ports oe0 and oe1, input, 8 bits each: requester pin enables.
REQ-008 The block SHALL have port gnt, output, 2 bits: registered one-hot grant, or all zero.
REQ-009 The block SHALL have ports uio_out and uio_oe, output, 8 bits each: pad drive value and pad enable.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, OWN0, OWN1 and GAP.
REQ-012 In IDLE with req!=0, the block SHALL select the requester that is requesting; if both request, it SHALL select the requester indicated by the round-robin pointer rr. Next state is OWNx, so gnt asserts exactly 1 cycle after req is sampled.
REQ-013 In OWNx: gnt[x]=1, uio_out=outx and uio_oe=oex, both combinational from the registered state.
REQ-014 In IDLE and GAP: gnt=0, uio_out=0 and uio_oe=0.
REQ-015 The hold counter SHALL be 8 bits, SHALL clear on entry to OWNx, and SHALL increment each OWN cycle, saturating at MAX_HOLD-1.
REQ-016 OWNx SHALL exit to GAP when req[x]=0, or when hold=MAX_HOLD-1 and the other requester's req=1. On exit, rr SHALL point to the other requester.
REQ-017 If req[x]=0 and the preemption condition are true in the same cycle, the single exit to GAP SHALL occur with identical behaviour.
REQ-018 If the owner holds and the other requester is idle, the owner SHALL keep the pins indefinitely, with the counter saturated.
REQ-019 GAP SHALL last exactly TURNAROUND cycles, counted by a 3-bit counter, then go to IDLE. The handoff latency from the owner's last OWN cycle to the new gnt is therefore TURNAROUND+2 cycles.
REQ-020 A requester dropping req while in GAP SHALL NOT be granted. A req pulse shorter than 1 sampled cycle in IDLE SHALL be ignored.
REQ-021 No cycle SHALL exist in which the two gnt bits are both 1.
REQ-022 No cycle SHALL exist in which uio_oe!=0 while gnt=0.

Reset
REQ-023 When rst=1 at a clk edge, the block SHALL enter IDLE and SHALL set rr=0, hold=0, gap counter=0, gnt=0 and busy=0; as a result uio_out=0 and uio_oe=0 in the following cycle.
REQ-024 Reset asserted during OWNx or GAP SHALL abort immediately, with no GAP sequence.
REQ-025 The pins SHALL be released on the first edge at which rst=1.

Structure
REQ-026 The state enum (IDLE, OWN0, OWN1, GAP) and the default constants for TURNAROUND and MAX_HOLD SHALL reside in the shared package uio_pkg.
REQ-027 The round-robin select logic and the rr register SHALL be the sub-module rr_pick2; all other logic SHALL stay flat.
REQ-028 The block SHALL contain no latches, and all registers SHALL be clocked by clk only.

Verification
REQ-029 Reset test: with rst=1 for 2 cycles and req=2'b11, gnt SHALL be 00, uio_oe SHALL be 00 and busy SHALL be 0 throughout; after rst is released, gnt SHALL be 01 one cycle later (rr=0).
REQ-030 Single owner test: req=01, out0=A5 and oe0=FF for 40 cycles; gnt SHALL be 01, uio_out SHALL be A5 and uio_oe SHALL be FF continuously, with no preemption.
REQ-031 Preemption test: req=11 held; the grant SHALL alternate OWN0 for 16 cycles, GAP for 1 cycle, 1 IDLE cycle, then OWN1 for 16 cycles, repeating; uio_oe SHALL be 00 during GAP and IDLE.
REQ-032 Voluntary release test: with requester 0 owning and req[0] dropped at cycle n, uio_oe SHALL be 00 from n+1, and gnt SHALL be 10 at n+3 if req[1]=1 (TURNAROUND=1).
REQ-033 Mid-grant reset test: rst=1 during OWN1 SHALL give gnt=00 and uio_oe=00 on the next cycle; after release with req=11, rr=0, so requester 0 SHALL win.
REQ-034 A bench assertion SHALL check REQ-021 and REQ-022 in every cycle of all scenarios, and all scenarios SHALL be rerun with TURNAROUND=3 and MAX_HOLD=2.
